dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Sequences and shares the single-port data memory (256 x 8, write on clock edge, synchronous read) between two requesters: the core load/store path and an external loader/debug port.
- Sits between the requesters and the data memory instance.
- Runs a fixed two-cycle access (issue, respond) per grant.
- Uses two-way round-robin so neither requester can starve the other.

Parameters:
- BITS, 8, data word width.
- MEMORY_BITS, 8, data memory address width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- core_req  input  1  core access request; held until core_ready.
- core_we  input  1  core write (1) / read (0); stable while core_req.
- core_addr  input  MEMORY_BITS  core address; stable while core_req.
- core_wdata  input  BITS  core write data; stable while core_req.
- core_rdata  output  BITS  core read data, valid only when core_ready.
- core_ready  output  1  one-cycle completion pulse for core.
- ext_req / ext_we / ext_addr / ext_wdata  input  1/1/MEMORY_BITS/BITS  external port, same rules as core.
- ext_rdata  output  BITS  external read data, valid only when ext_ready.
- ext_ready  output  1  one-cycle completion pulse for external port.
- mem_we  output  1  data memory write enable.
- mem_addr  output  MEMORY_BITS  data memory address.
- mem_wdata  output  BITS  data memory write data.
- mem_rdata  input  BITS  data memory read data, valid the cycle after the address is presented.
- busy  output  1  high in ISSUE and RESP.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, ISSUE, RESP. Registers: owner (CORE/EXT) and last_grant (CORE/EXT).
- Reset: state=IDLE, last_grant=EXT (core wins the first tie), owner=CORE.
- Reset output values: mem_we=0, mem_addr=0, mem_wdata=0, core_ready=ext_ready=0, core_rdata=ext_rdata=0, busy=0.
- mem_we is forced 0 in any cycle where rst=1. A write whose ISSUE cycle coincides with rst is dropped.
- Reset in ISSUE or RESP aborts the access. No ready pulse is produced; state returns to IDLE.
- IDLE transitions:
  - No request: stay in IDLE.
  - One request: owner takes that requester; go to ISSUE.
  - Both requests: owner = the requester that is not last_grant; go to ISSUE.
- ISSUE (1 cycle):
  - mem_addr and mem_wdata come from owner's inputs; mem_we = owner's we.
  - last_grant <= owner.
  - Next state: RESP.
- RESP (1 cycle):
  - mem_we=0; mem_addr holds owner's address.
  - The owner's ready is 1 and its rdata = mem_rdata (combinational pass-through), for reads and writes alike.
  - The non-owner's ready=0 and rdata=0.
- RESP transitions: the just-served requester's req is ignored this cycle, since it drops req only after seeing ready.
  - Other requester's req=1: owner <= other; go directly to ISSUE (back-to-back, no IDLE bubble).
  - Otherwise: go to IDLE.
- Timing:
  - Latency from req sampled in IDLE to ready: 2 cycles.
  - Sustained throughput: one access per 2 cycles.
  - Worst-case wait for a requester while the other is active: 4 cycles.
- Outside ISSUE, mem_we=0. Outside RESP, both ready=0 and both rdata=0.
- Any requester that keeps req high after its ready is treated as a new request and re-arbitrated against the other.
- Widths: addresses are passed through unmodified, with no wrap or arithmetic. Address 0xFF is legal.

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2.
  - Owner encoding OWN_CORE=1'b0, OWN_EXT=1'b1.
- One sub-module, rr_pick2: combinational two-way round-robin picker.
  - Inputs: req_a, req_b, last.
  - Outputs: valid, pick.
  - Reused in IDLE (both requesters) and RESP (other requester only).
- FSM and output muxing stay in dm_arbiter.

Test Plan:
- Single core read: mem holds 0x5A at 0x10; core_req, we=0, addr=0x10 at cycle 0 -> mem_addr=0x10 at cycle 1, core_ready=1 and core_rdata=0x5A at cycle 2, ext_ready=0 throughout.
- External write then core read, same address: ext writes 0x3C to 0x80; core then reads 0x80 -> mem_we=1 for exactly one cycle; core_rdata=0x3C on core_ready.
- Simultaneous requests after reset: core and ext both request at cycle 0 -> core served first (core_ready at cycle 2); ext goes straight to ISSUE at cycle 3, ext_ready at cycle 4, with no IDLE cycle between.
- Continuous contention: both requesters hold req for 12 cycles -> grants alternate CORE, EXT, CORE, ...; each requester gets exactly 3 ready pulses.
- Reset mid-write: ext write to 0x20 with rst=1 during its ISSUE cycle -> mem_we=0, no ext_ready, mem[0x20] unchanged, state IDLE next cycle, last_grant=EXT.
- Boundary address: core write 0xFF to address 0xFF, then read it back -> mem_addr=0xFF in both accesses, core_rdata=0xFF.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Holds the FSM state encoding and the owner encoding.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_EXT  = 1'b1;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view of the bundle.
interface dm_arbiter_if #(
    parameter int BITS        = 8,
    parameter int MEMORY_BITS = 8
);
    logic                   core_req;
    logic                   core_we;
    logic [MEMORY_BITS-1:0] core_addr;
    logic [BITS-1:0]        core_wdata;
    logic [BITS-1:0]        core_rdata;
    logic                   core_ready;

    logic                   ext_req;
    logic                   ext_we;
    logic [MEMORY_BITS-1:0] ext_addr;
    logic [BITS-1:0]        ext_wdata;
    logic [BITS-1:0]        ext_rdata;
    logic                   ext_ready;

    logic                   mem_we;
    logic [MEMORY_BITS-1:0] mem_addr;
    logic [BITS-1:0]        mem_wdata;
    logic [BITS-1:0]        mem_rdata;

    logic                   busy;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_ready,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_ready,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/dm_arbiter_rr_pick2.sv
// Two-way round-robin picker: pick=0 selects A, pick=1 selects B.
// On a tie the side that was not granted last wins.
module rr_pick2 (
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_last,
    output logic o_valid,
    output logic o_pick
);

    assign o_valid = i_req_a | i_req_b;
    assign o_pick  = (i_req_a & i_req_b) ? ~i_last : i_req_b;

endmodule

// File: rtl/dm_arbiter.sv
// Shares a single-port sync-read data memory between core and ext port.
// Each grant runs a fixed ISSUE/RESP pair; ties resolved round-robin.
import dm_arbiter_pkg::*;

module dm_arbiter #(
    parameter int BITS        = 8,
    parameter int MEMORY_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    dm_arbiter_if.slave bus
);

    state_t r_state;
    state_t w_next;
    logic   r_owner;
    logic   w_owner_nxt;
    logic   r_last;
    logic   w_last_nxt;

    logic w_idle_v;
    logic w_idle_pick;
    logic w_resp_v;
    logic w_resp_pick;
    logic w_core_oth;
    logic w_ext_oth;

    logic                   w_sel_we;
    logic [MEMORY_BITS-1:0] w_sel_addr;
    logic [BITS-1:0]        w_sel_wdata;
    logic                   w_issue;
    logic                   w_resp;
    logic                   w_act;

    rr_pick2 u_pick_idle (
        .i_req_a (bus.core_req),
        .i_req_b (bus.ext_req),
        .i_last  (r_last),
        .o_valid (w_idle_v),
        .o_pick  (w_idle_pick)
    );

    // In RESP the owner still holds req until it sees ready; mask it out.
    assign w_core_oth = bus.core_req & (r_owner != OWN_CORE);
    assign w_ext_oth  = bus.ext_req  & (r_owner != OWN_EXT);

    rr_pick2 u_pick_resp (
        .i_req_a (w_core_oth),
        .i_req_b (w_ext_oth),
        .i_last  (r_owner),
        .o_valid (w_resp_v),
        .o_pick  (w_resp_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_CORE;
            r_last  <= OWN_EXT;
        end else begin
            r_state <= w_next;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        unique case (r_state)
            ST_IDLE: begin
                if (w_idle_v) begin
                    w_owner_nxt = w_idle_pick;
                    w_next      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_last_nxt = r_owner;
                w_next     = ST_RESP;
            end
            ST_RESP: begin
                if (w_resp_v) begin
                    w_owner_nxt = w_resp_pick;
                    w_next      = ST_ISSUE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_sel_we    = (r_owner == OWN_EXT) ? bus.ext_we    : bus.core_we;
    assign w_sel_addr  = (r_owner == OWN_EXT) ? bus.ext_addr  : bus.core_addr;
    assign w_sel_wdata = (r_owner == OWN_EXT) ? bus.ext_wdata : bus.core_wdata;

    // Reset overrides every output so an in-flight access is fully aborted.
    assign w_issue = ~rst & (r_state == ST_ISSUE);
    assign w_resp  = ~rst & (r_state == ST_RESP);
    assign w_act   = w_issue | w_resp;

    assign bus.mem_we    = w_issue & w_sel_we;
    assign bus.mem_addr  = w_act   ? w_sel_addr  : '0;
    assign bus.mem_wdata = w_issue ? w_sel_wdata : '0;
    assign bus.busy      = w_act;

    assign bus.core_ready = w_resp & (r_owner == OWN_CORE);
    assign bus.ext_ready  = w_resp & (r_owner == OWN_EXT);
    assign bus.core_rdata = bus.core_ready ? bus.mem_rdata : '0;
    assign bus.ext_rdata  = bus.ext_ready  ? bus.mem_rdata : '0;

endmodule
